ex_operand_stage: RTL
=====================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus operand resolution for the execute stage; directly feeds the ALU.
//  Accepts one decoded instruction per cycle (valid/ready), applies EX/MEM/WB forwarding,
//  selects PC/rs1 and imm/rs2, then registers alu_data1_o/alu_data2_o/alu_op_code_o.
//  Detects load-use hazards (stalls ID, inserts bubble) and honours branch flush.
// PARAMETERS
//  XLEN   32  datapath width
//  OPW    4   ALU op-code width (matches ALU_* defines)
//  REGW   5   register index width
// PORTS
//  clk_i            in   1     clock, all state on rising edge
//  rst_i            in   1     synchronous reset, active-high
//  id_valid_i       in   1     decoded instruction available
//  id_ready_o       out  1     stage can accept this cycle
//  id_pc_i          in   XLEN  instruction PC
//  id_rs1_i/id_rs2_i in  REGW  source register indices
//  id_rs1_used_i/id_rs2_used_i in 1  source actually read (hazard qualifiers)
//  id_rs1_data_i/id_rs2_data_i in XLEN  register-file read data
//  id_imm_i         in   XLEN  sign-extended immediate
//  id_src1_pc_i     in   1     1: operand1=PC (AUIPC/JAL), 0: rs1
//  id_src2_imm_i    in   1     1: operand2=imm, 0: rs2
//  id_op_code_i     in   OPW   ALU op
//  id_rd_i          in   REGW  destination; id_rd_wen_i in 1 writes rd; id_is_load_i in 1 load
//  alu_res_i        in   XLEN  ALU result for instruction currently held here
//  mem_rd_i/mem_rd_wen_i/mem_rd_data_i  in REGW/1/XLEN  EX/MEM writeback candidate
//  wb_rd_i/wb_rd_wen_i/wb_rd_data_i     in REGW/1/XLEN  MEM/WB writeback candidate
//  flush_i          in   1     kill held and incoming instruction
//  ex_ready_i       in   1     downstream (EX/MEM) accepts held instruction
//  ex_valid_o       out  1     held instruction valid
//  alu_data1_o/alu_data2_o out XLEN  ALU operands; alu_op_code_o out OPW
//  ex_pc_o/ex_store_data_o out XLEN  PC, forwarded rs2 (store data)
//  ex_rd_o out REGW; ex_rd_wen_o/ex_is_load_o out 1
// BEHAVIOUR
//  - Reset: ex_valid_o=0, every data/control output 0; id_ready_o follows comb rule below.
//  - Forwarding per source, priority: held instr (ex_valid_o & ex_rd_wen_o & ~ex_is_load_o, alu_res_i)
//    > MEM > WB > register file. Match requires rd==rs, wen=1, rd!=0. rs==0 always yields 0.
//  - Load-use hazard: ex_valid_o & ex_is_load_o & ex_rd_wen_o & ex_rd_o!=0 & match on a used rs.
//  - id_ready_o = flush_i | (~hazard & (~ex_valid_o | ex_ready_i)). Combinational, no id_valid_i path.
//  - Capture (id_valid_i & id_ready_o & ~flush_i): next cycle all outputs reflect new instr, ex_valid_o=1.
//    operand1 = src1_pc ? pc : fwd_rs1; operand2 = src2_imm ? imm : fwd_rs2; store_data = fwd_rs2.
//  - Hazard & ex_ready_i: held instr leaves, ex_valid_o=0 (bubble); ID held; resolves next cycle via MEM fwd.
//  - ex_valid_o & ~ex_ready_i & ~flush_i: all outputs hold bit-stable (no re-forwarding).
//  - No capture & ex_ready_i: ex_valid_o=0; data outputs may hold stale values.
//  - flush_i: ex_valid_o=0 next cycle regardless of handshake/hazard; incoming dropped.
//  - Latency: 1 cycle ID->ALU inputs; throughput 1/cycle without hazards; reset mid-stream drops held instr.
//  - Widths: all operands XLEN, no arithmetic here; rd/rs compare full REGW.
// TESTING
//  1 Reset: rst_i=1 two cycles -> ex_valid_o=0, alu_data1_o=alu_data2_o=0, id_ready_o=1.
//  2 ADD x3,x1,x2 (RF x1=5,x2=7), then ADD x4,x3,x3 -> 2nd capture alu_data1_o=alu_data2_o=12 from alu_res_i.
//  3 LW x5 held, next ADD x6,x5,x0 -> id_ready_o=0 one cycle, bubble (ex_valid_o=0), then operand1=mem_rd_data_i.
//  4 MEM rd=x7=0x11 and WB rd=x7=0x22 both valid, consumer of x7 -> operand=0x11; rd=x0 with wen -> operand 0.
//  5 ex_ready_i=0 for 3 cycles with id_valid_i=1 -> outputs unchanged, id_ready_o=0; release -> next instr in 1 cycle.
//  6 flush_i=1 while valid held and id_valid_i=1 -> ex_valid_o=0 next cycle, id_ready_o=1, no capture.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with EX/MEM/WB operand forwarding, load-use stall and flush.
// Operands are resolved combinationally from ID inputs and registered straight into the ALU inputs.
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 4,
    parameter int REGW = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [REGW-1:0] id_rs1_i,
    input  logic [REGW-1:0] id_rs2_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic            id_src1_pc_i,
    input  logic            id_src2_imm_i,
    input  logic [OPW-1:0]  id_op_code_i,
    input  logic [REGW-1:0] id_rd_i,
    input  logic            id_rd_wen_i,
    input  logic            id_is_load_i,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic [REGW-1:0] mem_rd_i,
    input  logic            mem_rd_wen_i,
    input  logic [XLEN-1:0] mem_rd_data_i,
    input  logic [REGW-1:0] wb_rd_i,
    input  logic            wb_rd_wen_i,
    input  logic [XLEN-1:0] wb_rd_data_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] alu_data1_o,
    output logic [XLEN-1:0] alu_data2_o,
    output logic [OPW-1:0]  alu_op_code_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [REGW-1:0] ex_rd_o,
    output logic            ex_rd_wen_o,
    output logic            ex_is_load_o
);
    logic            ex_ok, mem_ok, wb_ok, ld_pend, hazard, capture;
    logic [XLEN-1:0] fwd1, fwd2;

    // A held load has no result yet, so it never forwards; it raises a hazard instead.
    always_comb begin
        ex_ok   = ex_valid_o & ex_rd_wen_o & ~ex_is_load_o & (ex_rd_o != '0);
        mem_ok  = mem_rd_wen_i & (mem_rd_i != '0);
        wb_ok   = wb_rd_wen_i & (wb_rd_i != '0);
        ld_pend = ex_valid_o & ex_is_load_o & ex_rd_wen_o & (ex_rd_o != '0);
        hazard  = ld_pend & ((id_rs1_used_i & (ex_rd_o == id_rs1_i)) |
                             (id_rs2_used_i & (ex_rd_o == id_rs2_i)));
        id_ready_o = flush_i | (~hazard & (~ex_valid_o | ex_ready_i));
        capture    = id_valid_i & id_ready_o & ~flush_i;
        fwd1 = (id_rs1_i == '0)                   ? '0 :
               (ex_ok  && ex_rd_o  == id_rs1_i)   ? alu_res_i :
               (mem_ok && mem_rd_i == id_rs1_i)   ? mem_rd_data_i :
               (wb_ok  && wb_rd_i  == id_rs1_i)   ? wb_rd_data_i : id_rs1_data_i;
        fwd2 = (id_rs2_i == '0)                   ? '0 :
               (ex_ok  && ex_rd_o  == id_rs2_i)   ? alu_res_i :
               (mem_ok && mem_rd_i == id_rs2_i)   ? mem_rd_data_i :
               (wb_ok  && wb_rd_i  == id_rs2_i)   ? wb_rd_data_i : id_rs2_data_i;
    end

    // Data registers only load on capture, so a stalled instruction stays bit-stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_o      <= 1'b0;
            alu_data1_o     <= '0;
            alu_data2_o     <= '0;
            alu_op_code_o   <= '0;
            ex_pc_o         <= '0;
            ex_store_data_o <= '0;
            ex_rd_o         <= '0;
            ex_rd_wen_o     <= 1'b0;
            ex_is_load_o    <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (capture) begin
            ex_valid_o      <= 1'b1;
            alu_data1_o     <= id_src1_pc_i ? id_pc_i : fwd1;
            alu_data2_o     <= id_src2_imm_i ? id_imm_i : fwd2;
            alu_op_code_o   <= id_op_code_i;
            ex_pc_o         <= id_pc_i;
            ex_store_data_o <= fwd2;
            ex_rd_o         <= id_rd_i;
            ex_rd_wen_o     <= id_rd_wen_i;
            ex_is_load_o    <= id_is_load_i;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end
endmodule
